// File: rtl/led_matrix_scanner.sv
// Row-scanning LED matrix driver with double-buffered frame store, row dwell and inter-row blanking.
// Optional macro LED_SCAN_BRIGHTNESS_EN adds a per-row brightness input that trims column on-time.
module led_matrix_scanner #(
   parameter int ROWS  = 5,
   parameter int COLS  = 7,
   parameter int DWELL = 1000,
   parameter int BLANK = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [ROWS*COLS-1:0]     frame_in,
   input  logic                     frame_valid,
   output logic                     frame_ready,
   output logic [ROWS-1:0]          row_out,
   output logic [COLS-1:0]          col_out,
   output logic                     frame_start,
   output logic [$clog2(ROWS)-1:0]  row_idx
`ifdef LED_SCAN_BRIGHTNESS_EN
   ,
   input  logic [$clog2(DWELL+1)-1:0] bright
`endif
);

   localparam int RW   = $clog2(ROWS);
   localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int PW   = $clog2(MAXC + 1);

   typedef enum logic {S_BLANK, S_DRIVE} state_t;

   state_t                r_state;
   logic [PW-1:0]         r_phase;
   logic [RW-1:0]         r_row;
   logic [ROWS*COLS-1:0]  r_active;
   logic [ROWS*COLS-1:0]  r_shadow;
   logic                  r_pending;

   logic                  w_last_blank;
   logic                  w_last_drive;
   logic                  w_row_last;
   logic [RW-1:0]         w_row_next;
   logic [ROWS-1:0]       w_onehot;
   logic [COLS-1:0]       w_cols;
   logic                  w_capture;

   assign w_last_blank = (r_phase == PW'(BLANK - 1));
   assign w_last_drive = (r_phase == PW'(DWELL - 1));
   assign w_row_last   = (r_row == RW'(ROWS - 1));
   assign w_row_next   = w_row_last ? '0 : r_row + RW'(1);
   assign w_onehot     = ROWS'(1) << r_row;
   assign w_capture    = frame_valid && frame_ready;

`ifdef LED_SCAN_BRIGHTNESS_EN
   localparam int BW = $clog2(DWELL + 1);
   localparam int CW = (PW > BW) ? PW : BW;
   logic [BW-1:0] r_bright;

   // Columns are lit only for the first r_bright cycles of each dwell.
   assign w_cols = (CW'(r_phase) < CW'(r_bright)) ? r_active[r_row*COLS +: COLS] : '0;
`else
   assign w_cols = r_active[r_row*COLS +: COLS];
`endif

   // Outputs are registered images of the FSM state, so they trail it by one cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_BLANK;
         r_phase     <= '0;
         r_row       <= '0;
         r_active    <= '0;
         r_shadow    <= '0;
         r_pending   <= 1'b0;
         frame_ready <= 1'b1;
         row_out     <= '0;
         col_out     <= '0;
         frame_start <= 1'b0;
         row_idx     <= '0;
`ifdef LED_SCAN_BRIGHTNESS_EN
         r_bright    <= '0;
`endif
      end else begin
         frame_start <= (r_state == S_BLANK) && (r_phase == '0) && (r_row == '0);
         row_idx     <= r_row;
         if (r_state == S_DRIVE) begin
            row_out <= w_onehot;
            col_out <= w_cols;
         end else begin
            row_out <= '0;
            col_out <= '0;
         end

         case (r_state)
            S_BLANK: begin
               if (w_last_blank) begin
                  r_state <= S_DRIVE;
                  r_phase <= '0;
`ifdef LED_SCAN_BRIGHTNESS_EN
                  r_bright <= bright;
`endif
               end else begin
                  r_phase <= r_phase + PW'(1);
               end
            end
            default: begin
               if (w_last_drive) begin
                  r_state <= S_BLANK;
                  r_phase <= '0;
                  r_row   <= w_row_next;
                  // Swap only at the frame boundary so a frame is never torn.
                  if (w_row_last && r_pending) begin
                     r_active    <= r_shadow;
                     r_pending   <= 1'b0;
                     frame_ready <= 1'b1;
                  end
               end else begin
                  r_phase <= r_phase + PW'(1);
               end
            end
         endcase

         // Ready implies no pending frame, so this never collides with the swap above.
         if (w_capture) begin
            r_shadow    <= frame_in;
            r_pending   <= 1'b1;
            frame_ready <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner (ROWS=5, COLS=7, DWELL=4, BLANK=1): per-cycle expected outputs
// are queued up front from hand-chosen frames, a negedge monitor pops and compares every cycle.
module tb_led_matrix_scanner;

   localparam int ROWS  = 5;
   localparam int COLS  = 7;
   localparam int DWELL = 4;
   localparam int BLANK = 1;
   localparam int RPER  = DWELL + BLANK;

   typedef struct packed {
      logic [4:0] row;
      logic [6:0] col;
      logic       fs;
      logic       rdy;
      logic [2:0] idx;
   } exp_t;

   logic        CLK;
   logic        RST;
   logic [34:0] frame_in;
   logic        frame_valid;
   logic        frame_ready;
   logic [4:0]  row_out;
   logic [6:0]  col_out;
   logic        frame_start;
   logic [2:0]  row_idx;
`ifdef LED_SCAN_BRIGHTNESS_EN
   logic [2:0]  bright;
`endif

   exp_t        q[$];
   logic        done;
   int          cur;
   int          n_vec;
   int          n_err;

   logic [34:0] fr_a;
   logic [34:0] fr_b;
   logic [34:0] fr_c;
   logic [34:0] fr_d;
   logic [34:0] fr_e;

   led_matrix_scanner #(
      .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .frame_in(frame_in),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .row_out(row_out),
      .col_out(col_out),
      .frame_start(frame_start),
      .row_idx(row_idx)
`ifdef LED_SCAN_BRIGHTNESS_EN
      ,
      .bright(bright)
`endif
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic push_reset();
      exp_t e;
      e     = '0;
      e.rdy = 1'b1;
      q.push_back(e);
   endtask

   // Expected outputs for one frame (or its first n cycles). frame_ready starts at init,
   // is 0 from frame-relative cycle lo and 1 again from cycle hi.
   task automatic push_frame(input logic [34:0] act, input int n, input logic init,
                             input int lo, input int hi);
      exp_t e;
      int   i;
      i = 0;
      for (int r = 0; r < ROWS; r++) begin
         for (int p = 0; p < RPER; p++) begin
            if (i < n) begin
               e.row = (p < BLANK) ? 5'd0 : 5'(1 << r);
               e.col = (p < BLANK) ? 7'd0 : act[r*COLS +: COLS];
               e.fs  = (r == 0) && (p == 0);
               e.idx = 3'(r);
               e.rdy = (i >= hi) ? 1'b1 : ((i >= lo) ? 1'b0 : init);
               q.push_back(e);
            end
            i++;
         end
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
      cur++;
   endtask

   task automatic goto(input int k);
      while (cur < k) step();
   endtask

   task automatic send(input logic [34:0] f, input int k);
      goto(k);
      frame_in    = f;
      frame_valid = 1'b1;
      goto(k + 1);
      frame_valid = 1'b0;
      frame_in    = '0;
   endtask

   // Stimulus: cycle k is the interval just after the k-th rising edge.
   initial begin
      RST         = 1'b1;
      frame_in    = '0;
      frame_valid = 1'b0;
      done        = 1'b0;
      cur         = 0;
`ifdef LED_SCAN_BRIGHTNESS_EN
      bright      = 3'd4;
`endif
      fr_a = 35'h4_0000_0001;
      fr_b = '1;
      fr_c = {7'h0F, 7'h78, 7'h56, 7'h34, 7'h12};
      fr_d = {7'h7F, 7'h55, 7'h2A, 7'h00, 7'h7F};
      fr_e = '1;

      push_reset(); push_reset(); push_reset();
      push_frame('0,   25, 1'b1, 99, 99);
      push_frame('0,   25, 1'b1,  3, 24);
      push_frame(fr_a, 25, 1'b1,  3, 24);
      push_frame(fr_c, 25, 1'b1, 24, 99);
      push_frame(fr_c, 25, 1'b0, 99, 24);
      push_frame(fr_d, 25, 1'b1, 99, 99);
      push_frame(fr_d, 13, 1'b1,  3, 99);
      push_reset();
      push_frame('0,   25, 1'b1, 99, 99);
      push_frame('0,   25, 1'b1, 99, 99);

      goto(3);
      RST = 1'b0;
      send(fr_a, 31);
      send(fr_b, 40);
      send(fr_c, 56);
      send(fr_d, 102);
      send(fr_e, 156);
      goto(166);
      RST = 1'b1;
      goto(167);
      RST = 1'b0;
      goto(218);
      done = 1'b1;
   end

   // Monitor: one scoreboard entry per cycle, compared at the falling edge.
   initial begin
      exp_t e;
      n_vec = 0;
      n_err = 0;
      @(posedge CLK);
      forever begin
         @(negedge CLK);
         if (done || $time > 64'd100000) break;
         if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if ({row_out, col_out, frame_start, frame_ready, row_idx} !== e) begin
               n_err++;
               $display("FAIL vec%0d: got row=%b col=%b fs=%b rdy=%b idx=%0d, want row=%b col=%b fs=%b rdy=%b idx=%0d",
                        n_vec, row_out, col_out, frame_start, frame_ready, row_idx,
                        e.row, e.col, e.fs, e.rdy, e.idx);
            end
         end
      end
      n_vec++;
      if (!done || q.size() != 0) begin
         n_err++;
         $display("FAIL drain: done=%0b leftover=%0d, want done=1 leftover=0", done, q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Parametrised row-scanning driver for an ROWS x COLS LED matrix. Generalises the fixed 5x7 column multiplexer and counter pair. Adds:
- a double-buffered frame store loaded by a valid/ready handshake;
- programmable row dwell time;
- anti-ghosting blanking between rows.

It sits between the message/character generator and the matrix pins.

Parameters:
ROWS, 5, number of matrix rows (>=2)
COLS, 7, number of matrix columns (>=1)
DWELL, 1000, CLK cycles each row is driven (>=1)
BLANK, 2, CLK cycles all outputs are off between rows (>=1)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
frame_in  input  ROWS*COLS  pixel data; bit r*COLS+c = row r, column c (1 = LED on)
frame_valid  input  1  frame_in is valid
frame_ready  output  1  shadow buffer empty; transfer occurs when frame_valid && frame_ready
row_out  output  ROWS  one-hot row enable; bit r = row r
col_out  output  COLS  column data for the currently driven row
frame_start  output  1  one-cycle pulse at the start of each frame
row_idx  output  clog2(ROWS)  index of the current row, for debug/visibility

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high. All outputs are registered.
- Reset values:
  - row_out=0, col_out=0, frame_ready=1, frame_start=0, row_idx=0.
  - Active and shadow buffers cleared to 0; pending flag = 0.
  - FSM in BLANK, phase counter = 0.
- FSM, two states:
  - BLANK: holds BLANK cycles; row_out=0, col_out=0. On the last cycle it moves to DRIVE with the same row_idx.
  - DRIVE: holds DWELL cycles; row_out = one-hot(row_idx), col_out = active[row_idx*COLS +: COLS]. On the last cycle it moves to BLANK and sets row_idx = (row_idx==ROWS-1) ? 0 : row_idx+1.
- Timing:
  - Phase counter resets to 0 on every state change.
  - Row period = BLANK+DWELL cycles; frame period = ROWS*(BLANK+DWELL) cycles.
  - First DRIVE of row 0 begins BLANK cycles after RST deasserts.
- frame_start is high on the first BLANK cycle of row 0, including the first cycle after reset. It is low at all other times.
- Handshake:
  - When frame_valid && frame_ready: frame_in is copied to shadow, pending is set, and frame_ready drops on the next cycle.
  - frame_valid while frame_ready=0 is ignored; no stall and no error.
- Swap:
  - On the DRIVE(ROWS-1) -> BLANK(0) transition, if pending=1, shadow is copied to active, pending is cleared and frame_ready=1 on the next cycle.
  - A swap therefore never changes data mid-frame (no tearing).
- Simultaneous capture and wrap: a capture in the wrap cycle cannot coincide with a swap, because ready=1 implies pending=0. The captured frame is displayed starting at the next frame boundary.
- Reset mid-operation: outputs go off immediately on the next edge, both buffers are lost, and the scan restarts at BLANK of row 0.
- Only one row_out bit is ever high. row_out and col_out are never both non-zero during BLANK.

Optional Feature:
Macro: LED_SCAN_BRIGHTNESS_EN
- With the macro:
  - Adds input port `bright`, width clog2(DWELL+1).
  - `bright` is sampled on entry to DRIVE. col_out is driven only while phase counter < sampled bright, and is 0 for the remainder of DRIVE.
  - row_out is unchanged. bright=0 gives a dark display; bright>=DWELL gives full on.
- Without the macro: the port is absent and columns are driven for the full DWELL.

Test Plan:
1. ROWS=5, COLS=7, DWELL=4, BLANK=1, with RST held 3 cycles then released:
   - row_out=0 for 1 cycle, then 5'b00001 for 4 cycles, 0 for 1 cycle, then 5'b00010.
   - frame_start pulses every 25 cycles.
   - col_out=0 throughout, since buffers are cleared.
2. Load a frame with only bit 0 and bit 34 set:
   - Visible from the next frame_start: row 0 gives col_out=7'b0000001; row 4 gives col_out=7'b1000000.
   - frame_ready returns to 1 at the swap.
3. Send a second frame while frame_ready=0:
   - It is ignored, and the first frame is displayed.
   - A retry after frame_ready=1 is accepted.
4. Assert frame_valid in the same cycle as the DRIVE(4) -> BLANK(0) wrap:
   - The old frame is shown for one more full frame; the new data appears 25 cycles later.
5. Assert RST during DRIVE of row 2:
   - Next cycle: row_out=0, col_out=0, frame_ready=1, row_idx=0.
   - Scan restarts exactly as in scenario 1.
6. With LED_SCAN_BRIGHTNESS_EN, DWELL=4, bright=2, all-ones frame:
   - Each DRIVE shows col_out=7'h7F for 2 cycles, then 0 for 2 cycles.
   - bright=0 gives col_out always 0.
